// File: rtl/matrix_gen_engine.sv
// matrix_gen_engine
//   Random-matrix generator. A start pulse latches the job (m x n, matrix
//   count, value ceiling). The job is checked once, then for every matrix the
//   engine requests a base address from the storage allocator and writes m*n
//   pseudo-random elements row-major through a valid/ready write port.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start               one-cycle job start pulse (honoured in IDLE only)
//   dim_m, dim_n        matrix rows / columns
//   count               number of matrices in the job
//   val_max             inclusive upper bound on element values
//   seed_load, seed_in  LFSR seed load (IDLE only; seed 0 maps to 16'hACE1)
//   req_valid/req_m/req_n   address request to the allocator
//   base_addr/addr_ready    allocator grant
//   wr_en/wr_ready/wr_addr/wr_data   element write port
//   mat_idx             index of the matrix being generated
//   busy, done, err     status; done and err are one-cycle pulses
//
// Optional feature
//   MATGEN_TIMEOUT_EN   when defined, REQ gives up after TIMEOUT cycles
//                       without a grant, pulses err and returns to IDLE.
module matrix_gen_engine #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 8,
   parameter int DIM_W   = 3,
   parameter int MAX_DIM = 5,
   parameter int CNT_W   = 3,
   parameter int MAX_CNT = 2,
   parameter int VAL_W   = 4,
   parameter int TIMEOUT = 1000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DIM_W-1:0]  dim_m,
   input  logic [DIM_W-1:0]  dim_n,
   input  logic [CNT_W-1:0]  count,
   input  logic [VAL_W-1:0]  val_max,
   input  logic              seed_load,
   input  logic [15:0]       seed_in,
   output logic              req_valid,
   output logic [DIM_W-1:0]  req_m,
   output logic [DIM_W-1:0]  req_n,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              addr_ready,
   output logic              wr_en,
   input  logic              wr_ready,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic [CNT_W-1:0]  mat_idx,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int EW = 2 * DIM_W;                 // holds m*n
   localparam logic [15:0]      SEED_DEF  = 16'hACE1;
   localparam logic [15:0]      LFSR_MASK = 16'hB400;
   localparam logic [DIM_W-1:0] MAX_DIM_L = DIM_W'(MAX_DIM);
   localparam logic [CNT_W-1:0] MAX_CNT_L = CNT_W'(MAX_CNT);

   typedef enum logic [2:0] {S_IDLE, S_CHECK, S_REQ, S_GEN, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [DIM_W-1:0]  m_q, m_d, n_q, n_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, mat_q, mat_d;
   logic [VAL_W-1:0]  vmax_q, vmax_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [EW-1:0]     elem_q, elem_d;
   logic [15:0]       lfsr_q, lfsr_d;
   logic              err_q, err_d;

   logic [EW-1:0]     total;
   logic [VAL_W-1:0]  cand;
   logic              cand_ok, in_gen, wr_fire, lfsr_shift, job_bad;

   assign total   = EW'(m_q) * EW'(n_q);
   assign cand    = lfsr_q[VAL_W-1:0];
   assign cand_ok = (cand <= vmax_q);
   assign in_gen  = (state_q == S_GEN);
   assign wr_fire = in_gen && cand_ok && wr_ready;
   // A stalled accepted candidate must hold; a rejected one is skipped at once.
   assign lfsr_shift = in_gen && (!cand_ok || wr_ready);
   assign job_bad = (m_q == '0) || (n_q == '0) || (m_q > MAX_DIM_L) ||
                    (n_q > MAX_DIM_L) || (cnt_q == '0) || (cnt_q > MAX_CNT_L);

`ifdef MATGEN_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
   logic [TW-1:0] tmo_q, tmo_d;

   // Counts REQ cycles; cleared whenever the engine is elsewhere.
   assign tmo_d = (state_q == S_REQ) ? tmo_q + TW'(1) : '0;

   always_ff @(posedge clk) begin
      if (rst) tmo_q <= '0;
      else     tmo_q <= tmo_d;
   end
`endif

   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      n_d     = n_q;
      cnt_d   = cnt_q;
      vmax_d  = vmax_q;
      base_d  = base_q;
      elem_d  = elem_q;
      mat_d   = mat_q;
      lfsr_d  = lfsr_q;
      err_d   = 1'b0;
      if (lfsr_shift)
         lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
      case (state_q)
         S_IDLE: begin
            if (seed_load) lfsr_d = (seed_in == 16'h0000) ? SEED_DEF : seed_in;
            if (start) begin
               m_d     = dim_m;
               n_d     = dim_n;
               cnt_d   = count;
               vmax_d  = val_max;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (job_bad) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               mat_d   = '0;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (addr_ready) begin
               base_d  = base_addr;
               elem_d  = '0;
               state_d = S_GEN;
            end
`ifdef MATGEN_TIMEOUT_EN
            else if (tmo_q == TMO_LAST) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end
`endif
         end
         S_GEN: begin
            if (wr_fire) begin
               if (elem_q == total - EW'(1)) begin
                  if (mat_q == cnt_q - CNT_W'(1)) begin
                     state_d = S_DONE;
                  end else begin
                     mat_d   = mat_q + CNT_W'(1);
                     state_d = S_REQ;
                  end
               end else begin
                  elem_d = elem_q + EW'(1);
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         m_q     <= '0;
         n_q     <= '0;
         cnt_q   <= '0;
         vmax_q  <= '0;
         base_q  <= '0;
         elem_q  <= '0;
         mat_q   <= '0;
         lfsr_q  <= SEED_DEF;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         n_q     <= n_d;
         cnt_q   <= cnt_d;
         vmax_q  <= vmax_d;
         base_q  <= base_d;
         elem_q  <= elem_d;
         mat_q   <= mat_d;
         lfsr_q  <= lfsr_d;
         err_q   <= err_d;
      end
   end

   assign req_valid = (state_q == S_REQ);
   assign req_m     = m_q;
   assign req_n     = n_q;
   assign wr_en     = in_gen && cand_ok;
   // Address/data are forced to zero outside GEN so the port is quiet at rest.
   assign wr_addr   = in_gen ? base_q + ADDR_W'(elem_q) : '0;
   assign wr_data   = in_gen ? DATA_W'(cand) : '0;
   assign mat_idx   = mat_q;
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign err       = err_q;

endmodule

// File: doc/matrix_gen_engine.md
Name: matrix_gen_engine

Overview:
- Parametrised random-matrix generator that follows the input parser in generation mode.
- Takes already-parsed dimensions m×n, a matrix count and a value ceiling.
- For each matrix, runs an address-request handshake with the storage allocator, then writes m·n pseudo-random elements row-major through a valid/ready write port.
- Generalises the earlier fixed generator with configurable widths and limits, a value range, a seedable LFSR and write backpressure.

Parameters:
- DATA_W, 32, width of a written element; the value is zero-extended into it.
- ADDR_W, 8, storage address width; addresses wrap modulo 2^ADDR_W.
- DIM_W, 3, width of the m/n inputs.
- MAX_DIM, 5, largest legal m or n.
- CNT_W, 3, width of the count input.
- MAX_CNT, 2, largest legal matrix count.
- VAL_W, 4, width of the value-ceiling input and of the candidate element.
- TIMEOUT, 1000, allocator wait limit in cycles; used only with MATGEN_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a generation job.
- dim_m  in  DIM_W  rows.
- dim_n  in  DIM_W  columns.
- count  in  CNT_W  number of matrices.
- val_max  in  VAL_W  inclusive upper bound on element values.
- seed_load  in  1  loads seed_in into the LFSR (IDLE only).
- seed_in  in  16  LFSR seed.
- req_valid  out  1  address request to the allocator (dims valid).
- req_m  out  DIM_W  latched m, presented with the request.
- req_n  out  DIM_W  latched n, presented with the request.
- base_addr  in  ADDR_W  allocated base address.
- addr_ready  in  1  allocator grant; base_addr is valid this cycle.
- wr_en  out  1  write valid.
- wr_ready  in  1  sink accepts the write.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  DATA_W  write data.
- mat_idx  out  CNT_W  index of the current matrix.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the job completes.
- err  out  1  one-cycle pulse on an invalid job or timeout.

Behaviour:
- Reset:
  - State returns to IDLE.
  - All outputs go to 0.
  - LFSR loads 16'hACE1; internal counters clear.
  - Reset mid-job abandons the job; no done or err pulse is produced.
- LFSR:
  - 16-bit Galois, mask 16'hB400.
  - Shifts only in GEN, on cycles where (!cand_ok || wr_ready).
  - A seed_load of 0 loads 16'hACE1 instead.
  - seed_load outside IDLE is ignored.
- Candidate: cand = lfsr[VAL_W-1:0]; cand_ok = (cand <= val_max_latched).
- IDLE:
  - start latches dim_m, dim_n, count and val_max, then moves to CHECK.
  - start in any other state is ignored.
- CHECK (1 cycle):
  - Invalid if m = 0, n = 0, m > MAX_DIM, n > MAX_DIM, count = 0 or count > MAX_CNT.
  - Invalid job: err pulses and the state returns to IDLE with no request issued.
  - Valid job: mat_idx ← 0 and the state moves to REQ.
- REQ:
  - req_valid = 1, with req_m and req_n stable.
  - On a clock edge with addr_ready = 1: base latched, elem_idx ← 0, state → GEN; req_valid is low the following cycle.
  - addr_ready outside REQ is ignored.
- GEN:
  - Write outputs are combinational from registers: wr_en = cand_ok, wr_addr = base + elem_idx (ADDR_W wrap), wr_data = zero-extended cand.
  - A write completes on a clock edge where wr_en && wr_ready; elem_idx then increments.
  - While wr_en = 1 and wr_ready = 0, wr_addr, wr_data and the LFSR hold.
  - A rejected candidate (cand > val_max) costs one cycle with no write.
  - When the write with elem_idx = m·n−1 completes: if mat_idx = count−1 the state moves to DONE; otherwise mat_idx increments and the state moves to REQ.
- DONE: done pulses for 1 cycle, then the state returns to IDLE; busy drops in IDLE.
- Latency: start → req_valid is 2 cycles. Element writes run at 1 per cycle when every candidate is accepted and wr_ready = 1.

Optional Feature:
- MATGEN_TIMEOUT_EN defined:
  - A cycle counter runs while in REQ.
  - If addr_ready has not arrived after TIMEOUT cycles, err pulses, req_valid drops and the state returns to IDLE with no done pulse.
  - Matrices already written are not rolled back.
- MATGEN_TIMEOUT_EN not defined: REQ waits indefinitely and the counter logic is absent.

Test Plan:
- Nominal job: m=2, n=3, count=2, val_max=9, wr_ready=1; grant base 100, then 200.
  -> Exactly 12 writes: addresses 100..105 then 200..205, every data ≤ 9.
  -> req_valid is asserted twice; done pulses once; err never asserts.
- Invalid jobs: m=0; then n=6; then count=3 (MAX_CNT=2).
  -> Each produces one err pulse 2 cycles after start, with no req_valid and no writes.
- Address wrap and backpressure: m=2, n=2, base 254, wr_ready toggles 1,0,0,1,…
  -> Writes go to addresses 254, 255, 0, 1.
  -> While wr_ready=0, wr_addr and wr_data hold.
  -> The data sequence is identical to a run with wr_ready held at 1 and the same seed.
- Range and seed: val_max=0, seed 16'h1234.
  -> Every wr_data = 0.
  -> Rerunning with the same seed gives identical cycle-by-cycle output; seed_load of 0 behaves like 16'hACE1.
- Reset mid-job: assert rst for 1 cycle during GEN after 3 writes.
  -> The next cycle shows busy=0, wr_en=0, no done, no err; a new start runs normally.
- Timeout (MATGEN_TIMEOUT_EN, TIMEOUT=50): withhold addr_ready.
  -> err pulses after 50 REQ cycles, followed by IDLE.
  -> With the macro undefined, req_valid is still high at 1000 cycles.
